nonogram_pipeline_sequencer: RTL and testbench

Control-only sequencer that runs the photo-to-puzzle pipeline in order: binarized photo → rescale filter → constraint generator → solver → solved display. It generates read/write addresses and strobes for the external photo, rescaled-row and constraint memories, issues start pulses, and counts returned words. It checks completion handshakes and enforces watchdog timeouts. It replaces the ad-hoc filter/generator state logic in the top level and drives the state code shown on the 7-segment display.

---
 rtl/nonogram_pipeline_sequencer.sv | 171 +++++++++++++++++
 tb/tb_nonogram_pipeline_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonogram_pipeline_sequencer.sv
// Sequences the photo -> rescale filter -> constraint generator -> solver -> display pipeline.
// Generates memory strobes and start pulses, counts returned words, checks handshakes and enforces a watchdog.
module nonogram_pipeline_sequencer #(
    parameter int PHOTO_ROWS     = 240,
    parameter int SMALL_ROWS     = 30,
    parameter int CONS_WORDS     = 70,
    parameter int TIMEOUT_CYCLES = 16777215
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       go_in,
    input  logic       abort_in,
    output logic [7:0] photo_rd_addr_out,
    output logic       photo_rd_en_out,
    output logic       filter_start_out,
    output logic       filter_row_valid_out,
    input  logic       filter_out_valid_in,
    input  logic       filter_done_in,
    output logic [4:0] small_wr_addr_out,
    output logic       small_wr_en_out,
    output logic [4:0] small_rd_addr_out,
    output logic       small_rd_en_out,
    output logic       gen_start_out,
    output logic       gen_row_valid_out,
    input  logic       gen_out_valid_in,
    input  logic       gen_done_in,
    output logic [6:0] cons_wr_addr_out,
    output logic       cons_wr_en_out,
    output logic       solver_start_out,
    input  logic       solver_done_in,
    output logic       display_en_out,
    output logic       busy_out,
    output logic       error_out,
    output logic [3:0] state_out,
    output logic [6:0] cons_count_out
);

    localparam int RD_MAX = (PHOTO_ROWS > SMALL_ROWS) ? PHOTO_ROWS : SMALL_ROWS;
    localparam int RD_W   = $clog2(RD_MAX + 1);
    localparam int SW_W   = $clog2(SMALL_ROWS + 1);
    localparam int CW_W   = $clog2(CONS_WORDS + 1);
    localparam logic [RD_W-1:0] PHOTO_N    = RD_W'(PHOTO_ROWS);
    localparam logic [RD_W-1:0] SMALL_RD_N = RD_W'(SMALL_ROWS);
    localparam logic [SW_W-1:0] SMALL_N    = SW_W'(SMALL_ROWS);
    localparam logic [CW_W-1:0] CONS_N     = CW_W'(CONS_WORDS);
    localparam logic [23:0]     WD_LAST    = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FFEED  = 4'd1,
        S_FDRAIN = 4'd2,
        S_GFEED  = 4'd3,
        S_GDRAIN = 4'd4,
        S_SOLVE  = 4'd5,
        S_DISP   = 4'd6,
        S_ERR    = 4'd7
    } state_t;

    state_t          state, state_n;
    logic [RD_W-1:0] rd_cnt, rd_n;
    logic [SW_W-1:0] sw_cnt, sw_n;
    logic [CW_W-1:0] cw_cnt, cw_n;
    logic [23:0]     wd_cnt, wd_n;
    logic            go_s, go_p, go_rise;
    logic            f_acc, g_acc, f_ovf, g_ovf, f_full, g_full, wd_hit;
    logic            chg, clr, p_en_n, s_en_n;

    always_comb begin
        go_rise         = go_s & ~go_p;
        f_acc           = (state == S_FFEED) || (state == S_FDRAIN);
        g_acc           = (state == S_GFEED) || (state == S_GDRAIN);
        f_ovf           = f_acc && filter_out_valid_in && (sw_cnt == SMALL_N);
        g_ovf           = g_acc && gen_out_valid_in && (cw_cnt == CONS_N);
        small_wr_en_out = f_acc && filter_out_valid_in && !f_ovf && !abort_in;
        cons_wr_en_out  = g_acc && gen_out_valid_in && !g_ovf && !abort_in;
        // A valid arriving with done is counted before the done is judged.
        f_full          = (sw_cnt + SW_W'(small_wr_en_out)) == SMALL_N;
        g_full          = (cw_cnt + CW_W'(cons_wr_en_out)) == CONS_N;
        wd_hit          = (wd_cnt == WD_LAST);

        state_n = state;
        case (state)
            S_IDLE, S_DISP: if (go_rise) state_n = S_FFEED;
            S_FFEED: begin
                if (f_ovf)                  state_n = S_ERR;
                else if (rd_cnt == PHOTO_N) state_n = S_FDRAIN;
            end
            S_FDRAIN: begin
                if (f_ovf)               state_n = S_ERR;
                else if (filter_done_in) state_n = f_full ? S_GFEED : S_ERR;
                else if (wd_hit)         state_n = S_ERR;
            end
            S_GFEED: begin
                if (g_ovf)                     state_n = S_ERR;
                else if (rd_cnt == SMALL_RD_N) state_n = S_GDRAIN;
            end
            S_GDRAIN: begin
                if (g_ovf)            state_n = S_ERR;
                else if (gen_done_in) state_n = g_full ? S_SOLVE : S_ERR;
                else if (wd_hit)      state_n = S_ERR;
            end
            S_SOLVE: begin
                if (solver_done_in) state_n = S_DISP;
                else if (wd_hit)    state_n = S_ERR;
            end
            S_ERR:   if (go_rise) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort_in) state_n = S_IDLE;

        chg    = (state_n != state);
        clr    = chg && ((state_n == S_IDLE) || (state_n == S_FFEED));
        p_en_n = (state == S_FFEED) && !chg;
        s_en_n = (state == S_GFEED) && !chg;
        rd_n   = chg ? '0 : (rd_cnt + RD_W'(p_en_n | s_en_n));
        sw_n   = clr ? '0 : (sw_cnt + SW_W'(small_wr_en_out));
        cw_n   = clr ? '0 : (cw_cnt + CW_W'(cons_wr_en_out));
        wd_n   = chg ? '0 : ((wd_cnt == 24'hFFFFFF) ? wd_cnt : wd_cnt + 24'd1);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state                <= S_IDLE;
            rd_cnt               <= '0;
            sw_cnt               <= '0;
            cw_cnt               <= '0;
            wd_cnt               <= '0;
            go_s                 <= 1'b0;
            go_p                 <= 1'b0;
            photo_rd_en_out      <= 1'b0;
            photo_rd_addr_out    <= '0;
            small_rd_en_out      <= 1'b0;
            small_rd_addr_out    <= '0;
            filter_row_valid_out <= 1'b0;
            gen_row_valid_out    <= 1'b0;
            filter_start_out     <= 1'b0;
            gen_start_out        <= 1'b0;
            solver_start_out     <= 1'b0;
            busy_out             <= 1'b0;
            error_out            <= 1'b0;
            display_en_out       <= 1'b0;
        end else begin
            state                <= state_n;
            rd_cnt               <= rd_n;
            sw_cnt               <= sw_n;
            cw_cnt               <= cw_n;
            wd_cnt               <= wd_n;
            go_s                 <= go_in;
            go_p                 <= go_s;
            photo_rd_en_out      <= p_en_n;
            photo_rd_addr_out    <= p_en_n ? 8'(rd_cnt) : 8'd0;
            small_rd_en_out      <= s_en_n;
            small_rd_addr_out    <= s_en_n ? 5'(rd_cnt) : 5'd0;
            // Row-valid delays are squashed on abort so nothing strobes after the abort edge.
            filter_row_valid_out <= photo_rd_en_out & ~abort_in;
            gen_row_valid_out    <= small_rd_en_out & ~abort_in;
            filter_start_out     <= chg && (state_n == S_FFEED);
            gen_start_out        <= chg && (state_n == S_GFEED);
            solver_start_out     <= chg && (state_n == S_SOLVE);
            busy_out             <= !((state_n == S_IDLE) || (state_n == S_DISP) || (state_n == S_ERR));
            error_out            <= (state_n == S_ERR);
            display_en_out       <= (state_n == S_DISP);
        end
    end

    assign state_out         = state;
    assign small_wr_addr_out = 5'(sw_cnt);
    assign cons_wr_addr_out  = 7'(cw_cnt);
    assign cons_count_out    = 7'(cw_cnt);

endmodule

// File: tb/tb_nonogram_pipeline_sequencer.sv
// Randomized scenario bench for nonogram_pipeline_sequencer; a monitor logs strobes and states,
// and a rule-level model predicts state sequence, address streams and pulse counts per run.
module tb_nonogram_pipeline_sequencer;

    localparam int PR = 240, SR = 30, CW = 70, TMO = 1000;

    logic clk_in = 1'b0, reset_n_in = 1'b0, go_in = 1'b0, abort_in = 1'b0;
    logic filter_out_valid_in = 1'b0, filter_done_in = 1'b0;
    logic gen_out_valid_in = 1'b0, gen_done_in = 1'b0, solver_done_in = 1'b0;
    logic [7:0] photo_rd_addr_out;
    logic       photo_rd_en_out, filter_start_out, filter_row_valid_out;
    logic [4:0] small_wr_addr_out, small_rd_addr_out;
    logic       small_wr_en_out, small_rd_en_out, gen_start_out, gen_row_valid_out;
    logic [6:0] cons_wr_addr_out, cons_count_out;
    logic       cons_wr_en_out, solver_start_out, display_en_out, busy_out, error_out;
    logic [3:0] state_out;
    logic [47:0] all_o;

    nonogram_pipeline_sequencer #(
        .PHOTO_ROWS(PR), .SMALL_ROWS(SR), .CONS_WORDS(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .go_in(go_in), .abort_in(abort_in),
        .photo_rd_addr_out(photo_rd_addr_out), .photo_rd_en_out(photo_rd_en_out),
        .filter_start_out(filter_start_out), .filter_row_valid_out(filter_row_valid_out),
        .filter_out_valid_in(filter_out_valid_in), .filter_done_in(filter_done_in),
        .small_wr_addr_out(small_wr_addr_out), .small_wr_en_out(small_wr_en_out),
        .small_rd_addr_out(small_rd_addr_out), .small_rd_en_out(small_rd_en_out),
        .gen_start_out(gen_start_out), .gen_row_valid_out(gen_row_valid_out),
        .gen_out_valid_in(gen_out_valid_in), .gen_done_in(gen_done_in),
        .cons_wr_addr_out(cons_wr_addr_out), .cons_wr_en_out(cons_wr_en_out),
        .solver_start_out(solver_start_out), .solver_done_in(solver_done_in),
        .display_en_out(display_en_out), .busy_out(busy_out), .error_out(error_out),
        .state_out(state_out), .cons_count_out(cons_count_out)
    );

    assign all_o = {photo_rd_addr_out, photo_rd_en_out, filter_start_out, filter_row_valid_out,
                    small_wr_addr_out, small_wr_en_out, small_rd_addr_out, small_rd_en_out,
                    gen_start_out, gen_row_valid_out, cons_wr_addr_out, cons_wr_en_out,
                    solver_start_out, display_en_out, busy_out, error_out, state_out, cons_count_out};

    always #5 clk_in = ~clk_in;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: logs every strobe and state change, sampled mid-cycle.
    int photo_q[$], small_w[$], small_r[$], cons_w[$], st_q[$], st_t[$];
    int n_fs, n_gs, n_ss, rv_err;
    logic prev_pe = 1'b0, prev_se = 1'b0;
    logic [3:0] last_st = 4'd0;
    always @(negedge clk_in) begin
        if (photo_rd_en_out) photo_q.push_back(int'(photo_rd_addr_out));
        if (small_wr_en_out) small_w.push_back(int'(small_wr_addr_out));
        if (small_rd_en_out) small_r.push_back(int'(small_rd_addr_out));
        if (cons_wr_en_out)  cons_w.push_back(int'(cons_wr_addr_out));
        if (filter_start_out) n_fs++;
        if (gen_start_out)    n_gs++;
        if (solver_start_out) n_ss++;
        if (filter_row_valid_out !== prev_pe) rv_err++;
        if (gen_row_valid_out !== prev_se)    rv_err++;
        prev_pe = photo_rd_en_out;
        prev_se = small_rd_en_out;
        if (state_out !== last_st) begin
            st_q.push_back(int'(state_out));
            st_t.push_back(cyc);
            last_st = state_out;
        end
    end

    task automatic clear_mon();
        photo_q.delete(); small_w.delete(); small_r.delete(); cons_w.delete();
        st_q.delete(); st_t.delete();
        n_fs = 0; n_gs = 0; n_ss = 0; rv_err = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (state_out !== s && n < budget) begin tick(); n++; end
        total++;
        if (state_out !== s) begin
            $display("FAIL %s: state=%0d want %0d after %0d cycles", tag, state_out, s, n);
            bad++;
        end
    endtask

    task automatic start_go(output int lat);
        go_in = 1'b0; tick(); tick();
        go_in = 1'b1;
        lat = 0;
        while (!filter_start_out && lat < 6) begin tick(); lat++; end
        go_in = 1'b0;
    endtask

    task automatic recover();
        if (state_out == 4'd7) begin
            go_in = 1'b1; tick(); tick(); tick();
            go_in = 1'b0; tick(); tick();
        end
    endtask

    // Drives n valids on one channel: n-1 at random spacing, the last only once draining.
    task automatic feed_phase(input bit gen, input int n, input bit join_done);
        for (int i = 0; i < n - 1; i++) begin
            if (state_out == 4'd7) break;
            repeat ($urandom_range(3, 0)) tick();
            if (gen) gen_out_valid_in = 1'b1; else filter_out_valid_in = 1'b1;
            tick();
            gen_out_valid_in = 1'b0; filter_out_valid_in = 1'b0;
        end
        if (state_out == 4'd7) return;
        wait_state(gen ? 4'd4 : 4'd2, 400, gen ? "reach_gen_drain" : "reach_filter_drain");
        if (gen) begin gen_out_valid_in = 1'b1; gen_done_in = join_done; end
        else begin filter_out_valid_in = 1'b1; filter_done_in = join_done; end
        tick();
        gen_out_valid_in = 1'b0; filter_out_valid_in = 1'b0;
        gen_done_in = 1'b0; filter_done_in = 1'b0;
        if (state_out == 4'd7 || join_done) return;
        repeat ($urandom_range(3, 0)) tick();
        if (gen) gen_done_in = 1'b1; else filter_done_in = 1'b1;
        tick();
        gen_done_in = 1'b0; filter_done_in = 1'b0;
    endtask

    // Reference model: expected outcome of one run from its handshake counts.
    int exp_seq[$];
    int exp_small, exp_sreads, exp_cons, exp_gs, exp_ss;
    task automatic model_run(input int nf, input int ng, input int sd);
        bit f_ok, g_ok;
        f_ok = (nf == SR);
        g_ok = f_ok && (ng == CW);
        exp_seq = '{1, 2};
        if (!f_ok) exp_seq.push_back(7);
        else begin
            exp_seq.push_back(3); exp_seq.push_back(4);
            if (!g_ok) exp_seq.push_back(7);
            else begin
                exp_seq.push_back(5);
                exp_seq.push_back(sd < 0 ? 7 : 6);
            end
        end
        exp_small  = (nf < SR) ? nf : SR;
        exp_sreads = f_ok ? SR : 0;
        exp_cons   = f_ok ? ((ng < CW) ? ng : CW) : 0;
        exp_gs     = f_ok ? 1 : 0;
        exp_ss     = g_ok ? 1 : 0;
    endtask

    task automatic test_reset();
        #23;
        total++;
        if (all_o !== 48'd0) begin $display("FAIL reset_hold: outputs=%h want 0", all_o); bad++; end
        tick(); reset_n_in = 1'b1; tick(); tick();
        total++;
        if (all_o !== 48'd0) begin $display("FAIL reset_release: outputs=%h want 0", all_o); bad++; end
    endtask

    // Covers nominal, back-to-back restart from DISPLAY, short/overflow counts,
    // valid+done coincidence, and the solve watchdog.
    int t_nf[7] = '{30, 30, 29, 30, 30, 30, 30};
    int t_ng[7] = '{70, 70, 70, 71, 70, 69, 70};
    bit t_fj[7] = '{0, 0, 0, 0, 1, 0, 0};
    bit t_gj[7] = '{0, 1, 0, 0, 0, 1, 0};
    int t_sd[7] = '{100, 40, 100, 100, 10, 10, -1};

    task automatic test_pipeline_runs();
        int lat, errs, fin, i5;
        for (int k = 0; k < 7; k++) begin
            recover();
            model_run(t_nf[k], t_ng[k], t_sd[k]);
            clear_mon();
            start_go(lat);
            total++;
            if (lat !== 2) begin $display("FAIL go_latency[%0d]: %0d want 2", k, lat); bad++; end
            feed_phase(1'b0, t_nf[k], t_fj[k]);
            if (state_out != 4'd7) feed_phase(1'b1, t_ng[k], t_gj[k]);
            if (state_out == 4'd4 || state_out == 4'd5) begin
                wait_state(4'd5, 5, "reach_solve");
                if (t_sd[k] >= 0) begin
                    repeat (t_sd[k]) tick();
                    solver_done_in = 1'b1; tick(); solver_done_in = 1'b0;
                end else wait_state(4'd7, TMO + 100, "timeout_error");
            end
            tick(); tick(); tick();
            fin = exp_seq[exp_seq.size() - 1];

            errs = (st_q.size() != exp_seq.size()) ? 1 : 0;
            for (int i = 0; i < st_q.size() && i < exp_seq.size(); i++) if (st_q[i] != exp_seq[i]) errs++;
            total++;
            if (errs != 0) begin
                $display("FAIL state_seq[%0d]: got %0d states (last %0d) want %0d (last %0d)",
                         k, st_q.size(), last_st, exp_seq.size(), fin);
                bad++;
            end
            errs = (photo_q.size() != PR) ? 1 : 0;
            for (int i = 0; i < photo_q.size(); i++) if (photo_q[i] != i) errs++;
            total++;
            if (errs != 0) begin $display("FAIL photo_reads[%0d]: count=%0d errs=%0d want %0d in order", k, photo_q.size(), errs, PR); bad++; end
            errs = (small_w.size() != exp_small) ? 1 : 0;
            for (int i = 0; i < small_w.size(); i++) if (small_w[i] != i) errs++;
            total++;
            if (errs != 0) begin $display("FAIL small_writes[%0d]: count=%0d want %0d", k, small_w.size(), exp_small); bad++; end
            errs = (small_r.size() != exp_sreads) ? 1 : 0;
            for (int i = 0; i < small_r.size(); i++) if (small_r[i] != i) errs++;
            total++;
            if (errs != 0) begin $display("FAIL small_reads[%0d]: count=%0d want %0d", k, small_r.size(), exp_sreads); bad++; end
            errs = (cons_w.size() != exp_cons) ? 1 : 0;
            for (int i = 0; i < cons_w.size(); i++) if (cons_w[i] != i) errs++;
            total++;
            if (errs != 0) begin $display("FAIL cons_writes[%0d]: count=%0d want %0d", k, cons_w.size(), exp_cons); bad++; end
            total++;
            if (n_fs !== 1 || n_gs !== exp_gs || n_ss !== exp_ss) begin
                $display("FAIL start_pulses[%0d]: f=%0d g=%0d s=%0d want 1 %0d %0d", k, n_fs, n_gs, n_ss, exp_gs, exp_ss);
                bad++;
            end
            total++;
            if (int'(cons_count_out) !== exp_cons) begin $display("FAIL cons_count[%0d]: %0d want %0d", k, cons_count_out, exp_cons); bad++; end
            total++;
            if ({display_en_out, error_out, busy_out} !== {fin == 6, fin == 7, 1'b0}) begin
                $display("FAIL final_flags[%0d]: disp=%b err=%b busy=%b want final state %0d", k, display_en_out, error_out, busy_out, fin);
                bad++;
            end
            total++;
            if (rv_err !== 0) begin $display("FAIL row_valid_delay[%0d]: %0d bad cycles want 0", k, rv_err); bad++; end
            if (t_sd[k] < 0) begin
                i5 = -1;
                for (int i = 0; i + 1 < st_q.size(); i++) if (st_q[i] == 5) i5 = i;
                total++;
                if (i5 < 0 || st_q[i5 + 1] != 7 || st_t[i5 + 1] - st_t[i5] != TMO) begin
                    $display("FAIL timeout_cycles: solve->error delta=%0d want %0d",
                             (i5 < 0) ? -1 : st_t[i5 + 1] - st_t[i5], TMO);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_abort_reset();
        int lat;
        recover();
        clear_mon();
        start_go(lat);
        feed_phase(1'b0, SR, 1'b0);
        wait_state(4'd3, 5, "abort_reach_gen_feed");
        tick(); tick(); tick();
        abort_in = 1'b1;
        tick();
        total++;
        if ({state_out, small_rd_en_out, gen_row_valid_out, gen_start_out, busy_out, cons_count_out} !== 15'd0) begin
            $display("FAIL abort_idle: state=%0d rd=%b rv=%b busy=%b cc=%0d want all 0",
                     state_out, small_rd_en_out, gen_row_valid_out, busy_out, cons_count_out);
            bad++;
        end
        abort_in = 1'b0;
        tick();
        total++;
        if (all_o !== 48'd0) begin $display("FAIL abort_quiet: outputs=%h want 0", all_o); bad++; end

        start_go(lat);
        repeat (5) tick();
        #2 reset_n_in = 1'b0;
        #1;
        total++;
        if (all_o !== 48'd0) begin $display("FAIL async_reset: outputs=%h want 0", all_o); bad++; end
        tick(); reset_n_in = 1'b1; tick();
        clear_mon();
        start_go(lat);
        tick(); tick(); tick();
        total++;
        if (photo_q.size() < 2 || photo_q[0] != 0 || photo_q[1] != 1) begin
            $display("FAIL restart_addr: reads=%0d first=%0d want 0,1", photo_q.size(),
                     (photo_q.size() > 0) ? photo_q[0] : -1);
            bad++;
        end
        abort_in = 1'b1; tick(); abort_in = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_pipeline_runs();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
